adder_sched: RTL
================

Name: adder_sched

Overview:
Sequencer/arbiter sharing one full_adder instance in the CGRA tile among NUM_REQ requesters.
- Grants the adder round-robin and drives its operand, carry and on_off controls.
- Chains carry across multi-word (multi-precision) operations.
- Returns each word's sum through a valid/ready response port tagged with the requester id.

Parameters:
WIDTH, 16, adder datapath width (matches full_adder width)
NUM_REQ, 4, number of requesters (>=1)
IDW, $clog2(NUM_REQ) min 1, requester id width (derived, not overridden)
TIMEOUT, 15, max EXEC cycles awaiting fa_ack (used only with optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_ready  out  NUM_REQ  per-requester word accepted (one-hot or zero)
req_a  in  NUM_REQ*WIDTH  operand A per requester, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  operand B, same packing
req_cin  in  NUM_REQ  initial carry, used on first word only
req_last  in  NUM_REQ  word is final word of the operation
fa_a  out  WIDTH  to full_adder a
fa_b  out  WIDTH  to full_adder b
fa_carry_in  out  1  to full_adder carry_in
fa_carry_listen  out  1  to full_adder carry_listen
fa_on_off  out  1  to full_adder on_off
fa_c  in  WIDTH  from full_adder c
fa_carry_out  in  1  from full_adder carry_out
fa_ack  in  1  from full_adder ack
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_id  out  IDW  owning requester
rsp_sum  out  WIDTH  word sum
rsp_carry  out  1  carry out of this word
rsp_last  out  1  final word of operation
rsp_err  out  1  adder timeout (tied 0 without optional feature)

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, rr pointer 0, carry reg 0, lock cleared. All outputs 0, including req_ready, fa_on_off and rsp_valid. Reset mid-operation aborts silently with no response.
- States: IDLE, EXEC, RESP, NEXT.
- IDLE:
  - Round-robin pick among req_valid, starting at the rr pointer.
  - req_ready[winner]=1 combinationally in the same cycle.
  - Latch a, b, last, id.
  - Carry reg <= req_cin[winner], first-word flag=1.
  - -> EXEC. No valid -> stay.
- EXEC:
  - fa_on_off=1; fa_a/fa_b from latched regs; fa_carry_in=carry reg; fa_carry_listen=1.
  - fa_ack ignored in the first EXEC cycle.
  - On fa_ack=1: capture fa_c -> rsp_sum, fa_carry_out -> rsp_carry and carry reg. -> RESP.
  - Minimum accept-to-rsp_valid latency: 3 cycles.
- RESP:
  - fa_on_off=0; rsp_valid=1, rsp_id/rsp_last stable until rsp_ready.
  - rsp_ready=1 with last -> rr pointer <= id+1 (mod NUM_REQ), unlock, -> IDLE.
  - rsp_ready=1 without last -> lock owner, -> NEXT.
  - rsp_ready low stalls indefinitely with outputs held.
- NEXT:
  - Only req_valid[owner] is considered; others get req_ready=0.
  - On valid: accept, latch, keep chained carry reg (req_cin ignored). -> EXEC.
  - Owner dropping valid: wait indefinitely.
- Width: sum is mod 2^WIDTH; carry propagates only between words of one operation.
- Simultaneous requests: strict rotation, no starvation; NUM_REQ=1 degenerates to a sequencer.

Optional Feature:
ADDER_SCHED_TIMEOUT_EN
- Defined: EXEC counter.
  - After TIMEOUT cycles without fa_ack: rsp_valid=1, rsp_err=1, rsp_sum=0, rsp_last=1.
  - After that response is accepted, the lock releases and the rr pointer advances.
- Undefined: no counter; rsp_err constant 0; EXEC waits forever.

Decomposition:
- adder_sched_pkg: state enum (IDLE, EXEC, RESP, NEXT), default WIDTH/NUM_REQ constants.
- Sub-module rr_arbiter (req vector + pointer -> one-hot grant + index), reusable by other tile schedulers.
- Bench instantiates adder_sched with full_adder.

Test Plan:
- Single word: req0 a=000A b=0005 cin=0 last=1 -> rsp id=0 sum=000F carry=0 last=1; fa_on_off low after.
- Carry out: req1 a=FFFF b=0001 cin=0 -> sum=0000 carry=1.
- Two-word chain: req2 words (FFFF+0001), (0000+0000) last on 2nd -> sums 0000 then 0001, carry 0. Req0 held valid throughout gets no grant until lock release.
- Fairness: all four valid, single-word each, rsp_ready=1 -> rsp_id order 0,1,2,3,0.
- Backpressure and reset: rsp_ready=0 for 5 cycles holds rsp stable. Reset low during EXEC -> next cycle all outputs 0, IDLE.
- Timeout (macro defined): fa_ack forced 0 -> rsp_err=1 after TIMEOUT=15 EXEC cycles; next requester then granted.

Source files
------------

// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_sched_pkg
// Brief    : Shared types and defaults for the shared-adder scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    // Id width never collapses to zero, even for a single requester.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin pick: request vector + start pointer -> one-hot grant
//            and winner index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    int pos;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % N;
            if (req[IDW'(pos)]) begin
                grant             = '0;
                grant[IDW'(pos)]  = 1'b1;
                idx               = IDW'(pos);
                valid             = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_sched.sv
`default_nettype none
// ============================================================================
// Module   : adder_sched
// Brief    : Round-robin sequencer sharing one full_adder among NUM_REQ
//            requesters, with carry chaining across multi-word operations.
//            Optional EXEC timeout enabled by ADDER_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  TIMEOUT = 15,
    localparam int IDW     = idw_of(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [WIDTH-1:0]         fa_a,
    output logic [WIDTH-1:0]         fa_b,
    output logic                     fa_carry_in,
    output logic                     fa_carry_listen,
    output logic                     fa_on_off,
    input  logic [WIDTH-1:0]         fa_c,
    input  logic                     fa_carry_out,
    input  logic                     fa_ack,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_last,
    output logic                     rsp_err
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               rcarry_q, rcarry_d;
    logic               last_q, last_d;
    logic               lock_q, lock_d;
    logic               first_q, first_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_valid;
    logic [IDW-1:0]     sel_idx;
    logic [IDW-1:0]     next_ptr;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               next_ok;
    logic               ack_ok;
    logic               in_exec;
    logic               in_resp;

    assign in_exec  = (state_q == ST_EXEC);
    assign in_resp  = (state_q == ST_RESP);
    assign arb_req  = (state_q == ST_IDLE) ? req_valid : '0;
    assign next_ok  = (state_q == ST_NEXT) && lock_q && req_valid[id_q];
    assign sel_idx  = (state_q == ST_NEXT) ? id_q : arb_idx;
    assign next_ptr = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
    // The adder's ack may be stale from setup in the first EXEC cycle.
    assign ack_ok   = fa_ack && !first_q;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_arb (
        .req   (arb_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE) begin
            req_ready = arb_grant;
        end else if (next_ok) begin
            req_ready[id_q] = 1'b1;
        end
    end

`ifdef ADDER_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    assign cnt_d       = in_exec ? cnt_q + CNT_W'(1) : '0;
    assign timeout_hit = in_exec && !ack_ok && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign rsp_err     = in_resp && err_q;
`else
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        rcarry_d = rcarry_q;
        last_d   = last_q;
        lock_d   = lock_q;
        first_d  = first_q;
`ifdef ADDER_SCHED_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    last_d  = req_last[arb_idx];
                    id_d    = arb_idx;
                    carry_d = req_cin[arb_idx];
                    first_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                first_d = 1'b0;
                if (ack_ok) begin
                    sum_d    = fa_c;
                    rcarry_d = fa_carry_out;
                    carry_d  = fa_carry_out;
`ifdef ADDER_SCHED_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = ST_RESP;
                end
`ifdef ADDER_SCHED_TIMEOUT_EN
                // Abandon the whole operation: forcing last releases the lock.
                else if (timeout_hit) begin
                    sum_d    = '0;
                    rcarry_d = 1'b0;
                    carry_d  = 1'b0;
                    last_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (last_q) begin
                        ptr_d   = next_ptr;
                        lock_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        lock_d  = 1'b1;
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                // Chained carry is kept; req_cin only seeds the first word.
                if (next_ok) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    last_d  = req_last[id_q];
                    first_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            rcarry_q <= 1'b0;
            last_q   <= 1'b0;
            lock_q   <= 1'b0;
            first_q  <= 1'b0;
`ifdef ADDER_SCHED_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            rcarry_q <= rcarry_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            first_q  <= first_d;
`ifdef ADDER_SCHED_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign fa_on_off       = in_exec;
    assign fa_carry_listen = in_exec;
    assign fa_a            = in_exec ? a_q : '0;
    assign fa_b            = in_exec ? b_q : '0;
    assign fa_carry_in     = in_exec && carry_q;

    assign rsp_valid = in_resp;
    assign rsp_id    = in_resp ? id_q : '0;
    assign rsp_sum   = in_resp ? sum_q : '0;
    assign rsp_carry = in_resp && rcarry_q;
    assign rsp_last  = in_resp && last_q;

endmodule
`default_nettype wire
